// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add unsigned multiplier with
// architectural HI/LO registers, a combinational read mux and move-to writes.
// A multiply takes WIDTH iterations; HI/LO only ever hold complete results.
module mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             sel_hi,
   output logic [WIDTH-1:0] rdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d;      // one extra bit holds the add carry
   logic [WIDTH-1:0] mreg_q, mreg_d;    // multiplier, shifted out LSB first
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic [WIDTH:0]     sum;
   logic [2*WIDTH:0]   shifted;

   // Next-state logic: accept/iterate/finish, plus move-to writes when idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mreg_d  = mreg_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      // One shift-add step on the current partial product.
      sum     = mreg_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
      shifted = {sum, mreg_q} >> 1;

      case (state_q)
         IDLE: begin
            if (start) begin
               // start wins over any simultaneous move-to write
               mcand_d = a;
               mreg_d  = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               if (wr_hi) hi_d = wdata;
               if (wr_lo) lo_d = wdata;
            end
         end
         RUN: begin
            acc_d  = shifted[2*WIDTH:WIDTH];
            mreg_d = shifted[WIDTH-1:0];
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               // after the last shift the top bit is always zero
               hi_d    = shifted[2*WIDTH-1:WIDTH];
               lo_d    = shifted[WIDTH-1:0];
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset aborts any multiply.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mreg_q  <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mreg_q  <= mreg_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy  = (state_q == RUN);
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;
   assign rdata = sel_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: scoreboard bench for mult_unit. Each issued multiply pushes
// its exact 64-bit product; a monitor pops and compares on every done pulse.
module tb_mult_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          wr_hi = 1'b0;
   logic          wr_lo = 1'b0;
   logic [W-1:0]  wdata = '0;
   logic          sel_hi = 1'b0;
   logic [W-1:0]  rdata;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   logic [63:0] exp_q[$];

   mult_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .sel_hi(sel_hi),
      .rdata(rdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", name, act);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding product.
   always @(negedge clk) begin
      if (!reset && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_done: got hi=0x%0h lo=0x%0h expected no done", hi, lo);
         end else begin
            chk("sb_product", {hi, lo}, exp_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Issue a multiply at the current negedge and follow it to done.
   // At busy cycle poke_at, a conflicting start + mthi is driven (must be ignored).
   task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input int poke_at, output int n);
      a = ta;
      b = tb_v;
      start = 1'b1;
      exp_q.push_back({32'd0, ta} * {32'd0, tb_v});
      @(negedge clk);
      start = 1'b0;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      chk("done_low_after_accept", {63'd0, done}, 64'd0);
      n = 0;
      while (busy && n < 40) begin
         n++;
         if (n == poke_at) begin
            start = 1'b1;
            a = 32'd9;
            b = 32'd9;
            wr_hi = 1'b1;
            wdata = 32'hDEAD;
         end
         @(negedge clk);
         start = 1'b0;
         wr_hi = 1'b0;
      end
      chk("busy_cycles", 64'(n), 64'(W));
      chk("done_pulse", {63'd0, done}, 64'd1);
   endtask

   initial begin
      int n;
      logic [W-1:0] ra, rb;

      // Reset state
      do_reset();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      sel_hi = 1'b1; #1;
      chk("rst_rdata_hi", {32'd0, rdata}, 64'd0);
      sel_hi = 1'b0; #1;
      chk("rst_rdata_lo", {32'd0, rdata}, 64'd0);

      // Basic multiply
      run(32'd6, 32'd7, 0, n);
      chk("basic_hilo", {hi, lo}, 64'd42);
      chk("basic_rdata", {32'd0, rdata}, 64'd42);
      @(negedge clk);
      chk("basic_done_single", {63'd0, done}, 64'd0);

      // Full-width products
      run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, n);
      chk("full_hi", {32'd0, hi}, 64'hFFFF_FFFE);
      chk("full_lo", {32'd0, lo}, 64'h1);
      run(32'h8000_0000, 32'd2, 0, n);
      chk("msb_hilo", {hi, lo}, {32'd1, 32'd0});
      @(negedge clk);

      // Start and mthi ignored while busy
      run(32'd3, 32'd5, 10, n);
      chk("ignore_hilo", {hi, lo}, 64'd15);
      @(negedge clk);
      chk("ignore_idle_busy", {63'd0, busy}, 64'd0);
      chk("ignore_idle_done", {63'd0, done}, 64'd0);

      // Move-to then move-from
      wr_hi = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h5678;
      @(negedge clk);
      wr_lo = 1'b0;
      sel_hi = 1'b1; #1;
      chk("mfhi", {32'd0, rdata}, 64'h1234);
      sel_hi = 1'b0; #1;
      chk("mflo", {32'd0, rdata}, 64'h5678);
      wr_lo = 1'b1; wdata = 32'hFFFF;
      run(32'd7, 32'd8, 0, n);
      chk("start_beats_mtlo", {32'd0, lo}, 64'd56);

      // Back-to-back: second start in the done cycle
      @(negedge clk);
      run(32'd2, 32'd3, 0, n);
      chk("b2b_first", {32'd0, lo}, 64'd6);
      run(32'd4, 32'd5, 0, n);
      chk("b2b_gap", 64'(n + 1), 64'd33);
      chk("b2b_second", {32'd0, lo}, 64'd20);
      @(negedge clk);

      // Reset mid-operation
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hABCD;
      @(negedge clk);
      wr_hi = 1'b0; wr_lo = 1'b0;
      a = 32'd100; b = 32'd100; start = 1'b1;
      exp_q.push_back(64'd10000);
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      chk("mid_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      n = done_cnt;
      repeat (40) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt), 64'(n));
      run(32'd2, 32'd2, 0, n);
      chk("after_abort", {hi, lo}, 64'd4);

      // Randomized multiplies, back-to-back and with idle gaps
      for (int i = 0; i < 24; i++) begin
         ra = $urandom();
         rb = $urandom();
         if (i % 6 == 0) rb = 32'hFFFF_FFFF;
         if (i % 6 == 1) ra = 32'd0;
         if ($urandom_range(1, 0) == 1) @(negedge clk);
         run(ra, rb, 0, n);
         sel_hi = 1'b1; #1;
         chk("rand_mfhi", {32'd0, rdata}, ({32'd0, ra} * {32'd0, rb}) >> 32);
         sel_hi = 1'b0;
      end

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative unsigned multiplier with architectural HI/LO registers, sitting downstream of the instruction decoder beside the ALU. It executes `multu` as a 32-cycle radix-2 shift-add operation and holds the 64-bit product in HI/LO. `mfhi` and `mflo` read those registers through a read mux; `mthi` and `mtlo` write them. The processor stalls on `busy`.

## Interface

- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits wide.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: issue `multu`. Sampled at the rising edge.
- `a`  in  WIDTH: multiplicand (rs).
- `b`  in  WIDTH: multiplier (rt).
- `wr_hi`  in  1: `mthi` write strobe.
- `wr_lo`  in  1: `mtlo` write strobe.
- `wdata`  in  WIDTH: data for `mthi`/`mtlo`.
- `sel_hi`  in  1: read select. 1 selects HI (`mfhi`); 0 selects LO (`mflo`).
- `rdata`  out  WIDTH: combinational read, `sel_hi ? hi : lo`.
- `busy`  out  1: multiply in progress. The processor must stall while this is high.
- `done`  out  1: one-cycle pulse indicating HI/LO have just been updated by a multiply.
- `hi`, `lo`  out  WIDTH each: architectural registers.

## Operation

- **States:**
  - IDLE: `busy`=0.
  - RUN: `busy`=1, iteration counter `cnt` in 0..WIDTH-1.
- **Reset:**
  - Forces IDLE.
  - Sets `hi`=0, `lo`=0, `done`=0, `busy`=0, `cnt`=0.
  - Clears internal `acc` and `mreg`.
  - A reset during RUN aborts the multiply and discards the partial product.
- **Accepting a multiply (IDLE, `start`=1 at edge):**
  - Latch `a` into `mcand`.
  - Load `mreg` ← `b` and `acc` ← 0, where `acc` is WIDTH+1 bits.
  - Set `cnt` ← 0 and go to RUN.
- **Each RUN edge (one iteration):**
  - `sum` = `mreg[0]` ? `acc` + {0,`mcand`} : `acc`. The width is WIDTH+1 and the carry is kept.
  - {`acc`,`mreg`} ← {`sum`,`mreg`} >> 1. This is a 2·WIDTH+1-bit logical shift right.
  - `cnt` ← `cnt`+1.
- **Final iteration (edge where `cnt`=WIDTH-1):**
  - `hi` ← upper WIDTH bits and `lo` ← lower WIDTH bits of the shifted result.
  - Go to IDLE and set `done`=1 for the following cycle.
  - `hi`/`lo` never show partial products.
- **Arithmetic:**
  - Unsigned only; no overflow is possible.
  - The full 2·WIDTH-bit product is exact.
  - `acc` needs one carry bit.
- **`start` while busy:** `start` asserted in RUN is ignored. It is neither queued nor restarted.
- **`mthi`/`mtlo`:**
  - In IDLE, `wr_hi` writes `hi` ← `wdata` and `wr_lo` writes `lo` ← `wdata` at the edge. Both may be asserted together.
  - In RUN, the writes are ignored.
  - In IDLE with `start` also asserted, `start` wins and the writes are ignored (the product overwrites HI/LO anyway).
- **Reads:**
  - `rdata` always reflects the current `hi`/`lo`.
  - During RUN it shows the previous result; the processor's stall makes this harmless.

## Timing

- **Edge numbering:** E0 is the edge that accepts `start`.
  - `busy` is high after E0 through E32.
  - The iterations occupy E1..E32.
  - `hi`/`lo` update at E32.
  - `busy` is low and `done` is high in the cycle after E32.
- **Latency:** 32 cycles from the accepting edge to the result being visible (WIDTH cycles in general). Throughput is one multiply per WIDTH+1 cycles.
- **Back-to-back:** `start` sampled in the `done` cycle (IDLE) is accepted. `done` is then low on the next cycle.
- **Reset values:**
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - `rdata`=0.

## Test plan

- **Basic multiply:** reset, then `start` with a=6, b=7. Expect `busy` high for exactly 32 cycles, then `hi`=0, `lo`=42, and a single-cycle `done`; `sel_hi`=0 gives `rdata`=42.
- **Full-width product:** a=b=0xFFFFFFFF. Expect `hi`=0xFFFFFFFE and `lo`=0x00000001. Also a=0x80000000, b=2 gives `hi`=1, `lo`=0.
- **Start and write ignored while busy:**
  - Start 3×5.
  - At cycle 10 pulse `start` with a=9, b=9, and assert `wr_hi` with `wdata`=0xDEAD.
  - Expect final `hi`=0, `lo`=15, a single `done`, and then IDLE.
- **Move-to then move-from:**
  - In IDLE write `wr_hi`/`wdata`=0x1234, then `wr_lo`/`wdata`=0x5678.
  - `sel_hi`=1 gives `rdata`=0x1234; `sel_hi`=0 gives 0x5678.
  - `start` together with `wr_lo` leaves `lo` equal to the product.
- **Back-to-back:** issue 2×3, then 4×5 in the `done` cycle. Expect `lo`=6, then `lo`=20 exactly 33 cycles later, each with one `done` pulse.
- **Reset mid-operation:**
  - Start 100×100 with `hi`/`lo` preloaded via mthi/mtlo.
  - Assert `reset` at cycle 16.
  - Expect `busy`=0, `done`=0, `hi`=`lo`=0, and no later `done`.
  - A subsequent 2×2 gives `lo`=4.
